// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Pipeline hazard controller for hazards that operand
//               forwarding cannot resolve. Compares the ID instruction's
//               sources against the EX and MEM destinations, freezes PC and
//               IF/ID and injects an ID/EX bubble on a stall, flushes IF/ID
//               on a taken branch, tracks the multi-cycle mult/div unit and
//               keeps a saturating stall-cycle counter.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : decoded fields of the instruction in ID
//   branch_taken      : branch resolved taken in ID this cycle
//   ex_reg_write, ex_mem_read, ex_dest_addr   : EX instruction info
//   mem_mem_read, mem_dest_addr               : MEM instruction info
//   ex_start_muldiv   : mult/div entered EX this cycle
//   stall_count_clr   : clear the stall counter (priority over counting)
//   pc_write, if_id_write, id_ex_bubble, if_id_flush : pipeline controls
//   muldiv_busy       : HI/LO unit busy (registered)
//   stall_count       : saturating stall-cycle counter
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_is_muldiv,
    input  logic             id_reads_hilo,
    input  logic             branch_taken,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dest_addr,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_dest_addr,
    input  logic             ex_start_muldiv,
    input  logic             stall_count_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_count
);

    // Reload value for the busy window; the unit is busy MD_LATENCY-1 cycles
    // after the issue cycle.
    localparam logic [7:0]       c_MD_RELOAD = 8'(MD_LATENCY - 1);
    localparam logic             c_MD_MULTI  = (MD_LATENCY > 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    md_state_t        r_state;
    md_state_t        w_state_next;
    logic [7:0]       r_md_cnt;
    logic [7:0]       w_md_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;

    // ------------------------------------------------------------------
    // Source matching: a source counts only when it is actually read and
    // is not $0, which is hard-wired and never a real dependency.
    // ------------------------------------------------------------------
    logic w_rs_valid;
    logic w_rt_valid;
    logic w_ex_match;
    logic w_mem_match;
    logic w_load_use;
    logic w_branch_ex;
    logic w_branch_mem;
    logic w_hilo_hazard;
    logic w_stall;

    assign w_rs_valid  = id_uses_rs && (id_rs_addr != 5'd0);
    assign w_rt_valid  = id_uses_rt && (id_rt_addr != 5'd0);

    assign w_ex_match  = (w_rs_valid && (ex_dest_addr == id_rs_addr)) ||
                         (w_rt_valid && (ex_dest_addr == id_rt_addr));
    assign w_mem_match = (w_rs_valid && (mem_dest_addr == id_rs_addr)) ||
                         (w_rt_valid && (mem_dest_addr == id_rt_addr));

    assign w_load_use    = ex_mem_read && w_ex_match;
    // Branches compare in ID, so any EX result and any MEM load result is
    // still too late to forward into the comparator.
    assign w_branch_ex   = id_is_branch && ex_reg_write && w_ex_match;
    assign w_branch_mem  = id_is_branch && mem_mem_read && w_mem_match;
    assign w_hilo_hazard = (r_state == S_BUSY) && (id_is_muldiv || id_reads_hilo);

    assign w_stall = w_load_use || w_branch_ex || w_branch_mem || w_hilo_hazard;

    // A stall overrides a taken branch: the branch outcome was computed on
    // stale operands and will be re-evaluated next cycle.
    assign pc_write     = rst ? 1'b1 : ~w_stall;
    assign if_id_write  = rst ? 1'b1 : ~w_stall;
    assign id_ex_bubble = rst ? 1'b0 :  w_stall;
    assign if_id_flush  = rst ? 1'b0 : (branch_taken && !w_stall);

    // ------------------------------------------------------------------
    // Mult/div occupancy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_md_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        case (r_state)
            S_IDLE: begin
                if (ex_start_muldiv && c_MD_MULTI) begin
                    w_state_next  = S_BUSY;
                    w_md_cnt_next = c_MD_RELOAD;
                end
            end
            S_BUSY: begin
                // A new issue while busy restarts the window.
                if (ex_start_muldiv && c_MD_MULTI) begin
                    w_md_cnt_next = c_MD_RELOAD;
                end else if (r_md_cnt <= 8'd1) begin
                    w_state_next  = S_IDLE;
                    w_md_cnt_next = 8'd0;
                end else begin
                    w_md_cnt_next = r_md_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_md_cnt_next = 8'd0;
            end
        endcase
    end

    assign muldiv_busy = (r_state == S_BUSY);

    // ------------------------------------------------------------------
    // Saturating stall counter; clear wins over a same-cycle stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall_count_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Directed self-checking bench for hazard_stall_unit. Drives a
//               MD_LATENCY=4 instance and a MD_LATENCY=1 instance from the
//               same stimulus and checks hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_is_branch;
    logic        id_is_muldiv;
    logic        id_reads_hilo;
    logic        branch_taken;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_dest_addr;
    logic        mem_mem_read;
    logic [4:0]  mem_dest_addr;
    logic        ex_start_muldiv;
    logic        stall_count_clr;

    logic        pc_write,     pc_write_1;
    logic        if_id_write,  if_id_write_1;
    logic        id_ex_bubble, id_ex_bubble_1;
    logic        if_id_flush,  if_id_flush_1;
    logic        muldiv_busy,  muldiv_busy_1;
    logic [15:0] stall_count,  stall_count_1;

    int n_vec;
    int n_err;

    hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_is_muldiv(id_is_muldiv),
        .id_reads_hilo(id_reads_hilo), .branch_taken(branch_taken),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_dest_addr(ex_dest_addr), .mem_mem_read(mem_mem_read),
        .mem_dest_addr(mem_dest_addr), .ex_start_muldiv(ex_start_muldiv),
        .stall_count_clr(stall_count_clr),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .muldiv_busy(muldiv_busy), .stall_count(stall_count)
    );

    hazard_stall_unit #(.MD_LATENCY(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_is_muldiv(id_is_muldiv),
        .id_reads_hilo(id_reads_hilo), .branch_taken(branch_taken),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_dest_addr(ex_dest_addr), .mem_mem_read(mem_mem_read),
        .mem_dest_addr(mem_dest_addr), .ex_start_muldiv(ex_start_muldiv),
        .stall_count_clr(stall_count_clr),
        .pc_write(pc_write_1), .if_id_write(if_id_write_1),
        .id_ex_bubble(id_ex_bubble_1), .if_id_flush(if_id_flush_1),
        .muldiv_busy(muldiv_busy_1), .stall_count(stall_count_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs_addr      = 5'd0;
        id_rt_addr      = 5'd0;
        id_uses_rs      = 1'b0;
        id_uses_rt      = 1'b0;
        id_is_branch    = 1'b0;
        id_is_muldiv    = 1'b0;
        id_reads_hilo   = 1'b0;
        branch_taken    = 1'b0;
        ex_reg_write    = 1'b0;
        ex_mem_read     = 1'b0;
        ex_dest_addr    = 5'd0;
        mem_mem_read    = 1'b0;
        mem_dest_addr   = 5'd0;
        ex_start_muldiv = 1'b0;
        stall_count_clr = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read  = 1'b1;
        ex_dest_addr = 5'd8;
        id_rs_addr   = 5'd8;
        id_uses_rs   = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_inputs();

        // ---------------- reset: outputs idle even with a hazard present
        rst = 1'b1;
        set_load_use();
        branch_taken = 1'b1;
        #1;
        chk("rst_pc_write",     32'(pc_write),     32'd1);
        chk("rst_if_id_write",  32'(if_id_write),  32'd1);
        chk("rst_bubble",       32'(id_ex_bubble), 32'd0);
        chk("rst_flush",        32'(if_id_flush),  32'd0);
        tick();
        tick();
        chk("rst_busy",         32'(muldiv_busy),  32'd0);
        chk("rst_count",        32'(stall_count),  32'd0);
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("idle_pc_write",    32'(pc_write),     32'd1);

        // ---------------- load-use on rs = $8
        set_load_use();
        #1;
        chk("lu_pc_write",      32'(pc_write),     32'd0);
        chk("lu_if_id_write",   32'(if_id_write),  32'd0);
        chk("lu_bubble",        32'(id_ex_bubble), 32'd1);
        chk("lu_flush",         32'(if_id_flush),  32'd0);
        tick();
        chk("lu_count",         32'(stall_count),  32'd1);

        // same with $0: never a hazard
        ex_dest_addr = 5'd0;
        id_rs_addr   = 5'd0;
        #1;
        chk("lu0_pc_write",     32'(pc_write),     32'd1);
        chk("lu0_bubble",       32'(id_ex_bubble), 32'd0);
        tick();
        chk("lu0_count",        32'(stall_count),  32'd1);

        // rt matches but is not used -> no stall; then used -> stall
        ex_dest_addr = 5'd8;
        id_rs_addr   = 5'd3;
        id_rt_addr   = 5'd8;
        id_uses_rt   = 1'b0;
        #1;
        chk("lu_rt_unused",     32'(pc_write),     32'd1);
        id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used",       32'(pc_write),     32'd0);
        tick();
        chk("lu_rt_count",      32'(stall_count),  32'd2);
        clear_inputs();

        // ---------------- branch hazard on EX result, taken branch
        id_is_branch = 1'b1;
        ex_reg_write = 1'b1;
        ex_dest_addr = 5'd9;
        id_rt_addr   = 5'd9;
        id_uses_rt   = 1'b1;
        branch_taken = 1'b1;
        #1;
        chk("br_pc_write",      32'(pc_write),     32'd0);
        chk("br_flush_held",    32'(if_id_flush),  32'd0);
        tick();
        chk("br_count",         32'(stall_count),  32'd3);
        ex_reg_write = 1'b0;
        #1;
        chk("br_flush",         32'(if_id_flush),  32'd1);
        chk("br_pc_resume",     32'(pc_write),     32'd1);
        tick();
        chk("br_count_hold",    32'(stall_count),  32'd3);

        // EX write match without a branch is forwardable
        id_is_branch = 1'b0;
        ex_reg_write = 1'b1;
        branch_taken = 1'b0;
        #1;
        chk("nobr_pc_write",    32'(pc_write),     32'd1);
        // branch waiting on a load in MEM
        clear_inputs();
        id_is_branch  = 1'b1;
        mem_mem_read  = 1'b1;
        mem_dest_addr = 5'd5;
        id_rs_addr    = 5'd5;
        id_uses_rs    = 1'b1;
        #1;
        chk("brmem_bubble",     32'(id_ex_bubble), 32'd1);
        tick();
        chk("brmem_count",      32'(stall_count),  32'd4);
        clear_inputs();

        // ---------------- mult/div busy window, MD_LATENCY=4
        ex_start_muldiv = 1'b1;           // cycle 0
        #1;
        chk("md_c0_busy",       32'(muldiv_busy),  32'd0);
        tick();                            // cycle 1
        ex_start_muldiv = 1'b0;
        chk("md_c1_busy",       32'(muldiv_busy),  32'd1);
        chk("md1_c1_busy",      32'(muldiv_busy_1), 32'd0);
        tick();                            // cycle 2
        chk("md_c2_busy",       32'(muldiv_busy),  32'd1);
        id_reads_hilo = 1'b1;
        #1;
        chk("md_c2_hilo_stall", 32'(pc_write),     32'd0);
        chk("md1_c2_no_stall",  32'(pc_write_1),   32'd1);
        tick();                            // cycle 3
        chk("md_c3_busy",       32'(muldiv_busy),  32'd1);
        chk("md_c3_count",      32'(stall_count),  32'd5);
        id_reads_hilo = 1'b0;
        id_is_muldiv  = 1'b1;
        #1;
        chk("md_c3_md_stall",   32'(id_ex_bubble), 32'd1);
        tick();                            // cycle 4
        chk("md_c4_busy",       32'(muldiv_busy),  32'd0);
        id_is_muldiv  = 1'b0;
        id_reads_hilo = 1'b1;
        #1;
        chk("md_c4_no_stall",   32'(pc_write),     32'd1);
        tick();
        chk("md_c4_count",      32'(stall_count),  32'd6);
        clear_inputs();

        // ---------------- reset in the middle of BUSY
        ex_start_muldiv = 1'b1;           // cycle 0
        tick();                            // cycle 1
        ex_start_muldiv = 1'b0;
        tick();                            // cycle 2
        chk("rb_c2_busy",       32'(muldiv_busy),  32'd1);
        rst = 1'b1;
        set_load_use();
        branch_taken = 1'b1;
        #1;
        chk("rb_pc_write",      32'(pc_write),     32'd1);
        chk("rb_if_id_write",   32'(if_id_write),  32'd1);
        chk("rb_bubble",        32'(id_ex_bubble), 32'd0);
        chk("rb_flush",         32'(if_id_flush),  32'd0);
        tick();                            // cycle 3
        chk("rb_c3_busy",       32'(muldiv_busy),  32'd0);
        chk("rb_c3_count",      32'(stall_count),  32'd0);
        rst = 1'b0;
        clear_inputs();
        tick();
        chk("rb_c4_busy",       32'(muldiv_busy),  32'd0);

        // ---------------- counter saturation and clear priority
        set_load_use();
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_count",        32'(stall_count),  32'd65535);
        tick();
        chk("sat_hold",         32'(stall_count),  32'd65535);
        stall_count_clr = 1'b1;
        tick();
        chk("clr_with_stall",   32'(stall_count),  32'd0);
        stall_count_clr = 1'b0;
        tick();
        chk("count_after_clr",  32'(stall_count),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller that handles the hazards operand forwarding cannot resolve. It inspects the instruction in ID against the instructions in EX and MEM. When the pipeline must hold, it freezes PC and IF/ID and injects a bubble into ID/EX. It also tracks the multi-cycle mult/div unit, flushes IF/ID on taken branches, and keeps a saturating stall-cycle counter for performance analysis.

## Interface
- MD_LATENCY, 4, cycles a mult/div occupies the HI/LO unit, counted from issue into EX; legal range 1..255
- CNT_W, 16, width of the stall performance counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- id_rs_addr  in  5  rs field of the instruction in ID
- id_rt_addr  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_is_branch  in  1  ID instruction is a register-comparing branch, resolved in ID
- id_is_muldiv  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- branch_taken  in  1  branch resolved taken in ID this cycle
- ex_reg_write  in  1  EX instruction writes the register file
- ex_mem_read  in  1  EX instruction is a load
- ex_dest_addr  in  5  EX destination register
- mem_mem_read  in  1  MEM instruction is a load
- mem_dest_addr  in  5  MEM destination register
- ex_start_muldiv  in  1  mult/div entered EX this cycle
- stall_count_clr  in  1  clear the stall counter
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- id_ex_bubble  out  1  zero the control fields entering ID/EX
- if_id_flush  out  1  zero the instruction entering IF/ID
- muldiv_busy  out  1  HI/LO unit busy
- stall_count  out  CNT_W  stall-cycle counter, saturating

## Operation
- A source matches only if its use flag is set and its address is non-zero. Register $0 never causes a hazard.
- Load-use: ex_mem_read=1 and ex_dest_addr matches an ID source -> stall.
- Branch hazard, only when id_is_branch=1:
  - ex_reg_write=1 and ex_dest_addr matches an ID source -> stall.
  - mem_mem_read=1 and mem_dest_addr matches an ID source -> stall.
- HI/LO hazard: muldiv_busy=1 and (id_is_muldiv or id_reads_hilo) -> stall.
- stall = OR of all hazards. Stall drives pc_write=0, if_id_write=0, id_ex_bubble=1.
- Flush: if_id_flush = branch_taken AND NOT stall. When stall and branch_taken coincide, the stall wins, because the branch was resolved on stale operands and is re-evaluated next cycle.
- Mult/div FSM, states IDLE and BUSY, with an 8-bit counter md_cnt:
  - IDLE: on ex_start_muldiv, if MD_LATENCY>1, load md_cnt=MD_LATENCY-1 and go to BUSY. Otherwise stay in IDLE.
  - BUSY: if md_cnt==1, go to IDLE; else decrement md_cnt.
  - ex_start_muldiv in BUSY reloads md_cnt=MD_LATENCY-1 and stays in BUSY. This is defensive; the HI/LO stall prevents it in normal operation.
- muldiv_busy = (state==BUSY). It is registered.
- stall_count: stall_count_clr takes priority and sets it to 0. Otherwise it increments on each cycle with stall=1 and holds at all-ones.

## Timing
- Hazard outputs are combinational from the current inputs and muldiv_busy, valid in the same cycle.
- muldiv_busy rises on the edge after ex_start_muldiv and stays high exactly MD_LATENCY-1 cycles.
- stall_count reflects the stall of cycle N after edge N.
- While rst=1, outputs are forced to idle values: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
- On the reset edge, state goes to IDLE, md_cnt=0, muldiv_busy=0 and stall_count=0.
- Reset during BUSY aborts the busy window; muldiv_busy=0 on the next cycle.
- clr and a stall in the same cycle -> stall_count=0, and that stall is not counted.

## Test plan
- Load-use: ex_mem_read=1, ex_dest_addr=8, id_rs_addr=8, id_uses_rs=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1, stall_count 0->1. Same with addr 0 -> no stall.
- Branch: id_is_branch=1, ex_reg_write=1, ex_dest_addr=9=id_rt_addr, branch_taken=1 -> stall=1, if_id_flush=0. Next cycle with no hazard -> if_id_flush=1, pc_write=1.
- Mult/div with MD_LATENCY=4: ex_start_muldiv pulse at cycle 0 -> muldiv_busy=1 in cycles 1-3 and 0 in cycle 4. id_reads_hilo=1 at cycle 2 stalls; at cycle 4 it does not. With MD_LATENCY=1 -> busy never asserts.
- Reset mid-BUSY: rst at cycle 2 -> muldiv_busy=0 from cycle 3, stall_count=0, outputs at idle values during rst.
- Counter: 70000 consecutive stall cycles with CNT_W=16 -> stall_count saturates at 65535. stall_count_clr together with a stall -> 0.
